// File: rtl/conv_stream_param.sv
// Streaming 1-D convolution: run-time filter load, one x frame, P parallel MAC lanes.
// Optional macro CONV_STREAM_RELU_EN clamps negative lane results to zero.
module conv_stream_param #(
  parameter int WIDTH = 16,
  parameter int LENX  = 64,
  parameter int LENF  = 33,
  parameter int P     = 4,
  parameter int LOGX  = $clog2(LENX),
  parameter int LOGF  = (LENF > 1) ? $clog2(LENF) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_f,
  input  logic                    s_valid_f,
  output logic                    s_ready_f,
  input  logic signed [WIDTH-1:0] s_data_in_x,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  output logic signed [WIDTH-1:0] m_data_out_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y,
  output logic                    busy
);
  localparam int LENY = LENX - LENF + 1;
  localparam int CW   = $clog2(LENF + 2);
  localparam int GW   = $clog2(LENX + P + 1);
  localparam int DW   = (P > 1) ? $clog2(P) : 1;
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_F, LOAD_X, COMPUTE, DRAIN} state_t;

  state_t                  state_reg;
  logic [LOGF-1:0]         f_cnt_reg;
  logic [LOGX-1:0]         x_cnt_reg;
  logic [CW-1:0]           cnt_reg;
  logic [GW-1:0]           g_reg;
  logic [DW-1:0]           idx_reg;
  logic [DW-1:0]           last_idx;
  logic                    f_loaded_reg;
  logic                    f_we, x_we, acc_clr, acc_en, latch_en;
  logic [LOGF-1:0]         f_raddr;
  logic signed [WIDTH-1:0] f_rd;
  logic signed [WIDTH-1:0] f_mem [LENF];
  logic [P-1:0][WIDTH-1:0] lane_res;
  logic [P-1:0][WIDTH-1:0] lane_buf;
  int                      remain;

  assign s_ready_f = (state_reg == LOAD_F);
  assign s_ready_x = (state_reg == LOAD_X);
  assign busy      = (state_reg != IDLE);

  assign f_we     = (state_reg == LOAD_F) && s_valid_f;
  assign x_we     = (state_reg == LOAD_X) && s_valid_x;
  assign acc_clr  = (state_reg == COMPUTE) && (cnt_reg == '0);
  assign acc_en   = (state_reg == COMPUTE) && (cnt_reg != '0) && (cnt_reg <= CW'(LENF));
  assign latch_en = (state_reg == COMPUTE) && (cnt_reg == CW'(LENF + 1));
  // Read issued at pass cycle n is consumed at cycle n+1 (registered read).
  assign f_raddr  = (cnt_reg < CW'(LENF)) ? LOGF'(cnt_reg) : '0;

  always_comb begin
    remain   = LENY - int'(g_reg);
    last_idx = (remain < P) ? DW'(remain - 1) : DW'(P - 1);
  end

  always_ff @(posedge clk) begin
    if (f_we) f_mem[f_cnt_reg] <= s_data_in_f;
    f_rd <= f_mem[f_raddr];
  end

  // Each lane owns a full copy of the frame so all lanes read in parallel.
  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    logic signed [WIDTH-1:0]   x_mem [LENX];
    logic signed [WIDTH-1:0]   x_rd;
    logic [LOGX-1:0]           x_raddr;
    logic [31:0]               x_addr_full;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   prod_sat, acc_sum, res, acc_reg, buf_reg;
    logic [WIDTH:0]            sum_wide;

    assign x_addr_full = 32'(g_reg) + 32'(gi) + 32'(cnt_reg);
    assign x_raddr     = (x_addr_full < 32'(LENX)) ? x_addr_full[LOGX-1:0] : '0;

    always_ff @(posedge clk) begin
      if (x_we) x_mem[x_cnt_reg] <= s_data_in_x;
      x_rd <= x_mem[x_raddr];
    end

    assign prod = (2*WIDTH)'(f_rd) * (2*WIDTH)'(x_rd);

    always_comb begin
      if ((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]))
        prod_sat = prod[WIDTH-1:0];
      else
        prod_sat = prod[2*WIDTH-1] ? MINV : MAXV;
    end

    assign sum_wide = {acc_reg[WIDTH-1], acc_reg} + {prod_sat[WIDTH-1], prod_sat};
    assign acc_sum  = (sum_wide[WIDTH] == sum_wide[WIDTH-1]) ? sum_wide[WIDTH-1:0]
                    : (sum_wide[WIDTH] ? MINV : MAXV);

`ifdef CONV_STREAM_RELU_EN
    assign res = acc_reg[WIDTH-1] ? '0 : acc_reg;
`else
    assign res = acc_reg;
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc_reg <= '0;
        buf_reg <= '0;
      end else begin
        if (acc_clr)     acc_reg <= '0;
        else if (acc_en) acc_reg <= acc_sum;
        if (latch_en)    buf_reg <= res;
      end
    end

    assign lane_res[gi] = res;
    assign lane_buf[gi] = buf_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      f_cnt_reg    <= '0;
      x_cnt_reg    <= '0;
      cnt_reg      <= '0;
      g_reg        <= '0;
      idx_reg      <= '0;
      f_loaded_reg <= 1'b0;
      m_valid_y    <= 1'b0;
      m_data_out_y <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (s_valid_f || !f_loaded_reg) begin
            state_reg <= LOAD_F;
            f_cnt_reg <= '0;
          end else if (s_valid_x) begin
            state_reg <= LOAD_X;
            x_cnt_reg <= '0;
          end
        end
        LOAD_F: begin
          if (s_valid_f) begin
            if (f_cnt_reg == LOGF'(LENF - 1)) begin
              f_cnt_reg    <= '0;
              f_loaded_reg <= 1'b1;
              x_cnt_reg    <= '0;
              state_reg    <= LOAD_X;
            end else begin
              f_cnt_reg <= f_cnt_reg + 1'b1;
            end
          end
        end
        LOAD_X: begin
          if (s_valid_x) begin
            if (x_cnt_reg == LOGX'(LENX - 1)) begin
              x_cnt_reg <= '0;
              g_reg     <= '0;
              cnt_reg   <= '0;
              state_reg <= COMPUTE;
            end else begin
              x_cnt_reg <= x_cnt_reg + 1'b1;
            end
          end
        end
        COMPUTE: begin
          // Lane 0 is presented straight from the accumulator while the buffer latches.
          if (cnt_reg == CW'(LENF + 1)) begin
            cnt_reg      <= '0;
            idx_reg      <= '0;
            m_valid_y    <= 1'b1;
            m_data_out_y <= lane_res[0];
            state_reg    <= DRAIN;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (m_ready_y) begin
            if (idx_reg == last_idx) begin
              m_valid_y <= 1'b0;
              idx_reg   <= '0;
              if (int'(g_reg) + P < LENY) begin
                g_reg     <= g_reg + GW'(P);
                state_reg <= COMPUTE;
              end else begin
                g_reg     <= '0;
                state_reg <= IDLE;
              end
            end else begin
              idx_reg      <= idx_reg + 1'b1;
              m_data_out_y <= lane_buf[idx_reg + 1'b1];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_stream_param.sv
// Self-checking bench for conv_stream_param (WIDTH=16, LENX=8, LENF=4, P=3).
// Honours CONV_STREAM_RELU_EN in its reference model and literal expectations.
module tb_conv_stream_param;
  localparam int W  = 16;
  localparam int LX = 8;
  localparam int LF = 4;
  localparam int NP = 3;
  localparam int LY = LX - LF + 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic signed [W-1:0] s_data_in_f = '0;
  logic                s_valid_f = 1'b0;
  logic                s_ready_f;
  logic signed [W-1:0] s_data_in_x = '0;
  logic                s_valid_x = 1'b0;
  logic                s_ready_x;
  logic signed [W-1:0] m_data_out_y;
  logic                m_valid_y;
  logic                m_ready_y = 1'b1;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_duty = 100;
  bit mon_en = 1'b0;
  int exp_q[$];
  int obs_q[$];
  int f_model[LF];

  conv_stream_param #(.WIDTH(W), .LENX(LX), .LENF(LF), .P(NP)) dut (
    .clk(clk), .reset(reset),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .m_data_out_y(m_data_out_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: y[k] = saturating sum of saturated products f[n]*x[k+n].
  function automatic void model_push(input int xa[LX]);
    for (int k = 0; k < LY; k++) begin
      longint acc = 0;
      for (int n = 0; n < LF; n++) acc = sat(acc + sat(longint'(f_model[n]) * xa[k+n]));
`ifdef CONV_STREAM_RELU_EN
      if (acc < 0) acc = 0;
`endif
      exp_q.push_back(int'(acc));
    end
  endfunction

  initial begin : ready_drv
    forever begin
      @(posedge clk); #1;
      m_ready_y = ($urandom_range(99) < ready_duty);
    end
  end

  initial begin : monitor
    bit prev_stall = 0;
    bit prev_valid = 0;
    int prev_data = 0;
    int last_hs = 0;
    int y;
    forever begin
      @(negedge clk);
      y = int'(m_data_out_y);
      if (!mon_en) begin
        prev_stall = 0;
        prev_valid = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", int'(m_valid_y), 1);
          chk("hold_data", y, prev_data);
        end
        if (m_valid_y && !prev_valid) chk("pass_latency", cyc - last_hs, LF + 2);
        if (m_valid_y) chk("ready_excl_drain", int'({s_ready_x, s_ready_f}), 0);
        if (s_valid_x && s_ready_x) last_hs = cyc + 1;
        if (m_valid_y && m_ready_y) begin
          last_hs = cyc + 1;
          obs_q.push_back(y);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL y_unexpected: got %0d, expected no output", y);
          end else begin
            chk("y_value", y, exp_q.pop_front());
          end
        end
        prev_stall = m_valid_y && !m_ready_y;
        prev_valid = m_valid_y;
        prev_data  = y;
      end
    end
  end

  task automatic send_f(input int arr[LF], input int duty);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < LF && guard < 2000) begin
      s_valid_f = ($urandom_range(99) < duty);
      s_data_in_f = W'(arr[i]);
      @(negedge clk); hs = s_valid_f && s_ready_f;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    s_valid_f = 1'b0;
    chk("f_load_done", i, LF);
    f_model = arr;
  endtask

  task automatic send_x(input int arr[LX], input int duty);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < LX && guard < 2000) begin
      s_valid_x = ($urandom_range(99) < duty);
      s_data_in_x = W'(arr[i]);
      @(negedge clk); hs = s_valid_x && s_ready_x;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    s_valid_x = 1'b0;
    chk("x_load_done", i, LX);
  endtask

  task automatic wait_done();
    int guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("frame_done", int'(busy) + exp_q.size(), 0);
  endtask

  task automatic run_frame(input int xa[LX], input int duty);
    obs_q.delete();
    model_push(xa);
    send_x(xa, duty);
    wait_done();
  endtask

  task automatic check_obs(input string name, input int lit[LY]);
    chk({name, "_count"}, obs_q.size(), LY);
    for (int i = 0; i < LY; i++)
      if (i < obs_q.size()) chk(name, obs_q[i], lit[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready_f"}, int'(s_ready_f), 0);
    chk({tag, "_ready_x"}, int'(s_ready_x), 0);
    chk({tag, "_valid_y"}, int'(m_valid_y), 0);
    chk({tag, "_data_y"}, int'(m_data_out_y), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ramp[LX];
    int xpos[LX];
    int xneg[LX];
    int xr[LX];
    int guard;
    for (int i = 0; i < LX; i++) begin
      ramp[i] = i + 1;
      xpos[i] = 32767;
      xneg[i] = -32768;
    end

    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;

    // Box filter on a ramp; pins the model to hand values before the DUT runs.
    send_f('{1, 1, 1, 1}, 100);
    obs_q.delete();
    model_push(ramp);
    chk("model_pin0", exp_q[0], 10);
    chk("model_pin4", exp_q[4], 26);
    send_x(ramp, 100);
    wait_done();
    check_obs("box_ramp", '{10, 14, 18, 22, 26});

    // Saturation in both directions with a filter reload through IDLE.
    send_f('{2, 2, 2, 2}, 100);
    run_frame(xpos, 100);
    check_obs("sat_pos", '{32767, 32767, 32767, 32767, 32767});
    run_frame(xneg, 100);
`ifdef CONV_STREAM_RELU_EN
    check_obs("sat_neg", '{0, 0, 0, 0, 0});
`else
    check_obs("sat_neg", '{-32768, -32768, -32768, -32768, -32768});
`endif

    send_f('{-1, 0, 0, 0}, 100);
    run_frame(ramp, 100);
`ifdef CONV_STREAM_RELU_EN
    check_obs("neg_tap", '{0, 0, 0, 0, 0});
`else
    check_obs("neg_tap", '{-1, -2, -3, -4, -5});
`endif

    // Random handshake duty, two frames with no filter reload in between.
    send_f('{3, -2, 5, 1}, 50);
    ready_duty = 50;
    for (int fr = 0; fr < 2; fr++) begin
      for (int i = 0; i < LX; i++) xr[i] = int'($urandom_range(2000)) - 1000;
      run_frame(xr, 50);
      chk("rand_count", obs_q.size(), LY);
    end

    // Reset in the middle of a drain.
    obs_q.delete();
    model_push(ramp);
    send_x(ramp, 100);
    guard = 0;
    while (!(obs_q.size() >= 2 && m_valid_y) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("mid_drain_reached", int'(guard < 2000), 1);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    s_valid_x = 1'b1;
    s_data_in_x = 16'sd7;
    repeat (12) begin
      @(negedge clk);
      chk("no_x_before_f", int'(s_ready_x), 0);
      @(posedge clk); #1;
    end
    s_valid_x = 1'b0;
    mon_en = 1'b1;
    ready_duty = 100;
    send_f('{1, 2, 0, 0}, 100);
    run_frame(ramp, 100);
    check_obs("after_reset", '{5, 8, 11, 14, 17});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
